// File: rtl/mc_control_if.sv
// mc_control_if: memory handshake and datapath control bundle between mc_control and the core.
interface mc_control_if;
  logic [4:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       mdr_write;
  logic       pc_write;
  logic       pc_src;
  logic       alusrc;
  logic       alusrc2;
  logic [1:0] aluop;
  logic [1:0] mtoreg;
  logic       regwr;
  logic       trap;
  logic [2:0] state;
  modport slave (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
           alusrc, alusrc2, aluop, mtoreg, regwr, trap, state
  );
  modport master (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
           alusrc, alusrc2, aluop, mtoreg, regwr, trap, state
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port.
// Define MC_CONTROL_INSTRET_EN to add the retired-instruction counter port instret.
module mc_control
`ifdef MC_CONTROL_INSTRET_EN
  #(parameter int INSTRET_W = 32)
`endif
(
  input  logic clk,
  input  logic rst_n,
  mc_control_if.slave bus
`ifdef MC_CONTROL_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [4:0] OP_R = 5'b01100, OP_LW = 5'b00000, OP_SW = 5'b01000,
                         OP_BEQ = 5'b11000, OP_AUIPC = 5'b00101;
  state_t     r_state, w_next;
  logic [4:0] r_op;
  logic       w_legal;
  assign w_legal   = bus.opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_AUIPC};
  assign bus.state = r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= bus.opcode;
    end
  always_comb begin
    w_next        = r_state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.iord      = 1'b0;
    bus.ir_write  = 1'b0;
    bus.mdr_write = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 1'b0;
    bus.alusrc    = 1'b0;
    bus.alusrc2   = 1'b0;
    bus.aluop     = 2'b00;
    bus.mtoreg    = 2'b00;
    bus.regwr     = 1'b0;
    bus.trap      = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        w_next       = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: w_next = w_legal ? EXEC : TRAP;
      EXEC, MEM: begin
        // ALU setup is held through MEM so the ALU-result address stays stable
        bus.alusrc  = r_op != OP_R && r_op != OP_BEQ;
        bus.alusrc2 = r_op != OP_AUIPC;
        bus.aluop   = r_op == OP_R ? 2'b10 : r_op == OP_BEQ ? 2'b01 : 2'b00;
        if (r_state == EXEC) begin
          bus.pc_write = r_op == OP_BEQ && bus.zero;
          bus.pc_src   = r_op == OP_BEQ;
          w_next       = r_op == OP_BEQ ? FETCH : (r_op == OP_LW || r_op == OP_SW) ? MEM : WB;
        end else begin
          bus.mem_req   = 1'b1;
          bus.iord      = 1'b1;
          bus.mem_we    = r_op == OP_SW;
          bus.mdr_write = bus.mem_ready && r_op == OP_LW;
          w_next        = !bus.mem_ready ? MEM : r_op == OP_LW ? WB : FETCH;
        end
      end
      WB: begin
        bus.regwr  = 1'b1;
        bus.mtoreg = r_op == OP_LW ? 2'b10 : 2'b01;
        w_next     = FETCH;
      end
      TRAP: bus.trap = 1'b1;
      default: w_next = IDLE;
    endcase
  end
`ifdef MC_CONTROL_INSTRET_EN
  logic w_retire;
  assign w_retire = (r_state == EXEC && r_op == OP_BEQ) ||
                    (r_state == MEM && r_op == OP_SW && bus.mem_ready) || r_state == WB;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) instret <= '0;
    else if (w_retire) instret <= instret + INSTRET_W'(1);
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: per-cycle scoreboard of expected state/control vectors for mc_control.
module tb_mc_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  mc_control_if b();
`ifdef MC_CONTROL_INSTRET_EN
  logic [31:0] instret;
  mc_control dut (.clk(clk), .rst_n(rst_n), .bus(b.slave), .instret(instret));
`else
  mc_control dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
`endif
  always #5 clk = ~clk;
  localparam logic [14:0] REQ = 15'h4000, WE = 15'h2000, IORD = 15'h1000, IRW = 15'h0800,
                          MDR = 15'h0400, PCW = 15'h0200, PCS = 15'h0100, AS = 15'h0080,
                          AS2 = 15'h0040, OPF = 15'h0020, OPB = 15'h0010, MTM = 15'h0008,
                          MTA = 15'h0004, RW = 15'h0002, TRP = 15'h0001;
  localparam logic [4:0] R = 5'b01100, LW = 5'b00000, SW = 5'b01000, BEQ = 5'b11000,
                         AUI = 5'b00101, ILL = 5'b11111;
  typedef struct {
    logic       rdy;
    logic       z;
    logic [4:0] op;
    logic [2:0] s;
    logic [14:0] o;
  } step_t;
  step_t q[$];
  step_t st;
  function automatic logic [14:0] outs();
    return {b.mem_req, b.mem_we, b.iord, b.ir_write, b.mdr_write, b.pc_write, b.pc_src,
            b.alusrc, b.alusrc2, b.aluop, b.mtoreg, b.regwr, b.trap};
  endfunction
  task automatic push(input logic rdy, input logic z, input logic [4:0] op,
                      input logic [2:0] s, input logic [14:0] o);
    step_t t;
    t.rdy = rdy; t.z = z; t.op = op; t.s = s; t.o = o;
    q.push_back(t);
  endtask
  task automatic test_reset();
    b.mem_ready = 1'b1; b.zero = 1'b0; b.opcode = 5'd0;
    repeat (2) begin
      @(negedge clk); #1;
      nvec++;
      if ({b.state, outs()} !== 18'd0) begin
        nerr++; $display("FAIL reset_hold: got %h want 0", {b.state, outs()});
      end
    end
`ifdef MC_CONTROL_INSTRET_EN
    nvec++;
    if (instret !== 32'd0) begin nerr++; $display("FAIL reset_instret: got %0d want 0", instret); end
`endif
    @(posedge clk); #2 rst_n = 1'b1;
    push(1, 0, R, 3'd0, 15'd0);
    while (q.size() > 0) begin
      st = q.pop_front();
      @(negedge clk); b.mem_ready = st.rdy; b.zero = st.z; b.opcode = st.op; #1;
      nvec++;
      if ({b.state, outs()} !== {st.s, st.o}) begin
        nerr++; $display("FAIL reset_idle: got %h want %h", {b.state, outs()}, {st.s, st.o});
      end
    end
  endtask
  task automatic check_instret(input string name, input int want);
`ifdef MC_CONTROL_INSTRET_EN
    nvec++;
    if (instret !== 32'(want)) begin
      nerr++; $display("FAIL %s_instret: got %0d want %0d", name, instret, want);
    end
`endif
  endtask
  task automatic test_rtype();
    push(1, 0, R, 3'd1, REQ | IRW | PCW);
    push(1, 0, R, 3'd2, 15'd0);
    push(1, 0, R, 3'd3, AS2 | OPF);
    push(1, 0, R, 3'd5, RW | MTA);
    while (q.size() > 0) begin
      st = q.pop_front();
      @(negedge clk); b.mem_ready = st.rdy; b.zero = st.z; b.opcode = st.op; #1;
      nvec++;
      if ({b.state, outs()} !== {st.s, st.o}) begin
        nerr++; $display("FAIL rtype: got %h want %h", {b.state, outs()}, {st.s, st.o});
      end
    end
    @(negedge clk); #1; check_instret("rtype", 1);
  endtask
  task automatic test_lw_wait();
    push(0, 0, LW, 3'd1, REQ);
    push(0, 0, LW, 3'd1, REQ);
    push(1, 0, LW, 3'd1, REQ | IRW | PCW);
    push(0, 0, LW, 3'd2, 15'd0);
    push(0, 0, LW, 3'd3, AS | AS2);
    push(0, 0, LW, 3'd4, REQ | IORD | AS | AS2);
    push(0, 0, LW, 3'd4, REQ | IORD | AS | AS2);
    push(1, 0, LW, 3'd4, REQ | IORD | AS | AS2 | MDR);
    push(0, 0, LW, 3'd5, RW | MTM);
    while (q.size() > 0) begin
      st = q.pop_front();
      b.mem_ready = st.rdy; b.zero = st.z; b.opcode = st.op; #1;
      nvec++;
      if ({b.state, outs()} !== {st.s, st.o}) begin
        nerr++; $display("FAIL lw_wait: got %h want %h", {b.state, outs()}, {st.s, st.o});
      end
      @(negedge clk);
    end
    #1; check_instret("lw", 2);
  endtask
  task automatic test_beq();
    push(1, 1, BEQ, 3'd1, REQ | IRW | PCW);
    push(1, 1, BEQ, 3'd2, 15'd0);
    push(1, 1, BEQ, 3'd3, AS2 | OPB | PCW | PCS);
    push(1, 0, BEQ, 3'd1, REQ | IRW | PCW);
    push(1, 0, BEQ, 3'd2, 15'd0);
    push(1, 0, BEQ, 3'd3, AS2 | OPB | PCS);
    push(0, 0, BEQ, 3'd1, REQ);
    while (q.size() > 0) begin
      st = q.pop_front();
      b.mem_ready = st.rdy; b.zero = st.z; b.opcode = st.op; #1;
      nvec++;
      if ({b.state, outs()} !== {st.s, st.o}) begin
        nerr++; $display("FAIL beq: got %h want %h", {b.state, outs()}, {st.s, st.o});
      end
      @(negedge clk);
    end
    #1; check_instret("beq", 4);
  endtask
  task automatic test_sw_auipc();
    push(1, 0, SW, 3'd1, REQ | IRW | PCW);
    push(1, 0, SW, 3'd2, 15'd0);
    push(1, 0, SW, 3'd3, AS | AS2);
    push(1, 0, SW, 3'd4, REQ | WE | IORD | AS | AS2);
    push(1, 1, AUI, 3'd1, REQ | IRW | PCW);
    push(1, 1, AUI, 3'd2, 15'd0);
    push(1, 1, AUI, 3'd3, AS);
    push(1, 1, AUI, 3'd5, RW | MTA);
    while (q.size() > 0) begin
      st = q.pop_front();
      b.mem_ready = st.rdy; b.zero = st.z; b.opcode = st.op; #1;
      nvec++;
      if ({b.state, outs()} !== {st.s, st.o}) begin
        nerr++; $display("FAIL sw_auipc: got %h want %h", {b.state, outs()}, {st.s, st.o});
      end
      @(negedge clk);
    end
    #1; check_instret("sw_auipc", 6);
  endtask
  task automatic test_trap();
    push(1, 0, ILL, 3'd1, REQ | IRW | PCW);
    push(1, 0, ILL, 3'd2, 15'd0);
    for (int i = 0; i < 20; i++) push(1'($urandom), 1'($urandom), 5'($urandom), 3'd6, TRP);
    while (q.size() > 0) begin
      st = q.pop_front();
      b.mem_ready = st.rdy; b.zero = st.z; b.opcode = st.op; #1;
      nvec++;
      if ({b.state, outs()} !== {st.s, st.o}) begin
        nerr++; $display("FAIL trap: got %h want %h", {b.state, outs()}, {st.s, st.o});
      end
      @(negedge clk);
    end
    #1; check_instret("trap", 6);
    rst_n = 1'b0; #1;
    nvec++;
    if ({b.state, outs()} !== 18'd0) begin
      nerr++; $display("FAIL trap_reset: got %h want 0", {b.state, outs()});
    end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask
  task automatic test_reset_mid_sw();
    push(1, 0, SW, 3'd0, 15'd0);
    push(1, 0, SW, 3'd1, REQ | IRW | PCW);
    push(1, 0, SW, 3'd2, 15'd0);
    push(0, 0, SW, 3'd3, AS | AS2);
    push(0, 0, SW, 3'd4, REQ | WE | IORD | AS | AS2);
    while (q.size() > 0) begin
      st = q.pop_front();
      @(negedge clk); b.mem_ready = st.rdy; b.zero = st.z; b.opcode = st.op; #1;
      nvec++;
      if ({b.state, outs()} !== {st.s, st.o}) begin
        nerr++; $display("FAIL mid_sw: got %h want %h", {b.state, outs()}, {st.s, st.o});
      end
    end
    rst_n = 1'b0; #1;
    nvec++;
    if ({b.state, b.mem_req, b.mem_we, outs()} !== 20'd0) begin
      nerr++; $display("FAIL mid_sw_abort: got %h want 0", {b.state, outs()});
    end
    b.mem_ready = 1'b1;
    @(negedge clk); #1; check_instret("mid_sw", 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1;
    nvec++;
    if ({b.state, outs()} !== 18'd0) begin
      nerr++; $display("FAIL mid_sw_idle: got %h want 0", {b.state, outs()});
    end
    @(negedge clk); #1;
    nvec++;
    if ({b.state, outs()} !== {3'd1, REQ | IRW | PCW}) begin
      nerr++; $display("FAIL mid_sw_refetch: got %h want %h", {b.state, outs()}, {3'd1, REQ | IRW | PCW});
    end
    check_instret("mid_sw_refetch", 0);
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_sw_auipc();
    test_trap();
    test_reset_mid_sw();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
